mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the single-ported unified instruction/data memory. Shares one memory port between the instruction-fetch stage (read-only) and the load/store stage (read/write) using valid/ready handshakes. Issues at most one memory access per cycle and converts byte addresses to word indices. Returns each result through a registered, held response channel.

## Interface
- `ADDR_WIDTH`, default 32: requester byte-address width.
- `DATA_WIDTH`, default 32: word width.
- `MEM_AW`, default 15: memory word-index width; depth is 2**MEM_AW.
- `MAX_STREAK`, default 4: maximum consecutive data grants allowed while fetch waits (fairness build only); must be ≥1.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `if_req_valid`  in  1  fetch request.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_addr`  in  ADDR_WIDTH  fetch byte address.
- `if_rsp_valid`  out  1  fetch response held.
- `if_rsp_ready`  in  1  fetch response consumed.
- `if_rsp_data`  out  DATA_WIDTH  fetched word.
- `d_req_valid`  in  1  data request.
- `d_req_ready`  out  1  data request accepted.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_WIDTH  data byte address.
- `d_wdata`  in  DATA_WIDTH  store data.
- `d_rsp_valid`  out  1  data response held.
- `d_rsp_ready`  in  1  data response consumed.
- `d_rsp_data`  out  DATA_WIDTH  load word; store data echo on stores.
- `mem_addr`  out  MEM_AW  memory word index.
- `mem_we`  out  1  memory write enable.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_rdata`  in  DATA_WIDTH  memory read data; combinational from `mem_addr`.

## Operation
- **FSM states:**
  - IDLE: no response outstanding.
  - RESP_I: fetch response held.
  - RESP_D: data response held.
- **Grant window:** `grant_ok` = (state == IDLE) OR (held response valid AND its ready is high).
- **Arbitration:** with `grant_ok`, exactly one of `if_req_ready` / `d_req_ready` may assert.
  - Only one requester valid: that requester wins.
  - Both valid: data wins.
  - Exception (fairness build): fetch wins when the streak counter equals MAX_STREAK.
- **Ready dependence:** `if_req_ready` and `d_req_ready` depend combinationally on both request valids.
- **Granted access, cycle t:**
  - `mem_addr` = granted byte address[MEM_AW+1:2]; bits [1:0] are ignored.
  - `mem_we` = `d_we` on a data grant, else 0.
  - `mem_wdata` = `d_wdata`.
  - The memory writes at the posedge ending cycle t.
- **No grant:** `mem_we` = 0; `mem_addr`/`mem_wdata` hold the last driven value (don't-care for verification).
- **Response capture:** at the end of t, `mem_rdata` (reads) or `d_wdata` (stores) is captured into the winner's response register, and the FSM moves to RESP_I or RESP_D.
- **Response release:** on `rsp_valid && rsp_ready` with no new grant, the FSM returns to IDLE.
- **Back-to-back:** with a new grant in the same cycle, the FSM goes directly to the new RESP state. This gives a sustained throughput of 1 access/cycle.
- **Mutual exclusion:** `if_rsp_valid` and `d_rsp_valid` are never high together.
- **Reset (asynchronous, anytime):**
  - State IDLE.
  - `if_rsp_valid` = `d_rsp_valid` = 0.
  - Response data = 0.
  - Streak counter = 0.
  - While `reset_n` is low: `if_req_ready` = `d_req_ready` = `mem_we` = 0.
  - A response in flight is dropped; a store granted in the reset cycle is not performed.

## Timing
- Request → response valid: 1 cycle (accept at edge k, `rsp_valid` high after edge k).
- A response stays stable until it is consumed; an unconsumed response blocks all grants.
- `mem_we` is combinational from the grant, high for exactly one cycle per accepted store.
- Simultaneous fetch+data requests: the loser sees ready = 0 and must hold its request stable.

## Configuration
- **`MEM_ARB_FAIRNESS_EN` defined:**
  - Streak counter width = $clog2(MAX_STREAK+1).
  - Increments on a data grant while `if_req_valid` = 1.
  - Clears on a fetch grant, or on a data grant while `if_req_valid` = 0.
  - Saturates at MAX_STREAK; at that value, fetch wins the next contested grant.
- **Undefined:** strict data priority; no counter; fetch can starve.

## Test plan
- **Reset hold-off:** assert `reset_n` = 0 with both valids high → ready = 0, `mem_we` = 0, both `rsp_valid` = 0. Release → data granted first.
- **Store then load:** store 0xDEADBEEF to byte address 0x40, then load 0x40 → `mem_addr` = 0x10 with `mem_we` = 1 for one cycle; next load response = 0xDEADBEEF one cycle after accept.
- **Back-pressure:** hold `d_rsp_ready` = 0 for 3 cycles → `d_rsp_data` stable; no grants issued; fetch starts the cycle `d_rsp_ready` rises.
- **Streaming:** 8 consecutive fetches of 0x0,0x4,…,0x1C with `rsp_ready` = 1 → 8 responses on 8 consecutive cycles, `mem_addr` = 0..7.
- **Fairness:** both valids held with MAX_STREAK = 4.
  - With the macro: grant pattern D,D,D,D,I repeating.
  - Without: all D.
- **Reset mid-flight:** assert `reset_n` low while `if_rsp_valid` = 1 → `if_rsp_valid` drops immediately; FSM returns to IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the shared single-port memory.
// Optional fetch fairness: define MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 15,
  parameter int MAX_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_rsp_valid,
  input  logic                  if_rsp_ready,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_rsp_valid,
  input  logic                  d_rsp_ready,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    RESP_I,
    RESP_D
  } state_t;

  state_t state;

  logic                  ifRspValidQ;
  logic                  dRspValidQ;
  logic [DATA_WIDTH-1:0] ifRspDataQ;
  logic [DATA_WIDTH-1:0] dRspDataQ;
  logic [MEM_AW-1:0]     lastAddr;

  logic grantOk;
  logic fetchTurn;
  logic dWins;
  logic ifWins;
  logic ifGrant;
  logic dGrant;

  logic [MEM_AW-1:0] ifWord;
  logic [MEM_AW-1:0] dWord;

  // Low address bits and upper bits beyond the memory are not used.
  logic unusedAddr;
  assign unusedAddr = ^{if_addr, d_addr};

  assign ifWord = if_addr[MEM_AW+1:2];
  assign dWord  = d_addr[MEM_AW+1:2];

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  logic [SW-1:0] streak;

  assign fetchTurn = (streak == STREAK_MAX);

  // Count data grants that made a waiting fetch lose.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak <= '0;
    end else if (dGrant) begin
      if (!if_req_valid) begin
        streak <= '0;
      end else if (streak != STREAK_MAX) begin
        streak <= streak + 1'b1;
      end
    end else if (ifGrant) begin
      streak <= '0;
    end
  end
`else
  assign fetchTurn = 1'b0;
`endif

  // Grant window: idle, or the held response leaves this cycle.
  always_comb begin
    grantOk = 1'b0;
    unique case (state)
      IDLE:    grantOk = 1'b1;
      RESP_I:  grantOk = if_rsp_ready;
      RESP_D:  grantOk = d_rsp_ready;
      default: grantOk = 1'b0;
    endcase
  end

  // Data wins a contest unless fetch has been starved long enough.
  always_comb begin
    dWins   = d_req_valid && !(if_req_valid && fetchTurn);
    ifWins  = if_req_valid && !dWins;
    dGrant  = reset_n && grantOk && dWins;
    ifGrant = reset_n && grantOk && ifWins;
  end

  assign if_req_ready = ifGrant;
  assign d_req_ready  = dGrant;

  // Drive the memory port from the winner; keep the last index otherwise.
  always_comb begin
    mem_addr = lastAddr;
    if (dGrant) begin
      mem_addr = dWord;
    end else if (ifGrant) begin
      mem_addr = ifWord;
    end
  end

  assign mem_we    = dGrant && d_we;
  assign mem_wdata = d_wdata;

  // Remember the last driven index so an idle port stays quiet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lastAddr <= '0;
    end else if (dGrant || ifGrant) begin
      lastAddr <= mem_addr;
    end
  end

  // Response FSM: capture the granted result, release on consume.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ifRspValidQ <= 1'b0;
      dRspValidQ  <= 1'b0;
      ifRspDataQ  <= '0;
      dRspDataQ   <= '0;
    end else if (dGrant) begin
      state       <= RESP_D;
      ifRspValidQ <= 1'b0;
      dRspValidQ  <= 1'b1;
      dRspDataQ   <= d_we ? d_wdata : mem_rdata;
    end else if (ifGrant) begin
      state       <= RESP_I;
      ifRspValidQ <= 1'b1;
      dRspValidQ  <= 1'b0;
      ifRspDataQ  <= mem_rdata;
    end else if (grantOk) begin
      state       <= IDLE;
      ifRspValidQ <= 1'b0;
      dRspValidQ  <= 1'b0;
    end
  end

  assign if_rsp_valid = ifRspValidQ;
  assign d_rsp_valid  = dRspValidQ;
  assign if_rsp_data  = ifRspDataQ;
  assign d_rsp_data   = dRspDataQ;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory.
// Fairness expectations follow MEM_ARB_FAIRNESS_EN.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic        if_rsp_ready;
  logic [31:0] if_rsp_data;
  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_rsp_valid;
  logic        d_rsp_ready;
  logic [31:0] d_rsp_data;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:32767];

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_addr      (if_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_ready (if_rsp_ready),
    .if_rsp_data  (if_rsp_data),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rsp_valid  (d_rsp_valid),
    .d_rsp_ready  (d_rsp_ready),
    .d_rsp_data   (d_rsp_data),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  typedef struct {
    string       name;
    logic        ifv;
    logic [31:0] ifa;
    logic        dv;
    logic        we;
    logic [31:0] da;
    logic [31:0] wd;
    logic        expIfRdy;
    logic        expDRdy;
    logic        expWe;
    logic        chkAddr;
    logic [14:0] expAddr;
    int          expRsp;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic setIn(input logic ifv, input logic [31:0] ifa,
                       input logic dv, input logic we,
                       input logic [31:0] da, input logic [31:0] wd,
                       input logic irr, input logic drr);
    if_req_valid = ifv;
    if_addr      = ifa;
    d_req_valid  = dv;
    d_we         = we;
    d_addr       = da;
    d_wdata      = wd;
    if_rsp_ready = irr;
    d_rsp_ready  = drr;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 32'hA500_0000 | i;

    vecs[0] = '{"store40", 0, 0, 1, 1, 32'h40, 32'hDEAD_BEEF,
                0, 1, 1, 1, 15'h10, 2, 32'hDEAD_BEEF};
    vecs[1] = '{"load40", 0, 0, 1, 0, 32'h40, 0,
                0, 1, 0, 1, 15'h10, 2, 32'hDEAD_BEEF};
    vecs[2] = '{"fetch08", 1, 32'h8, 0, 0, 0, 0,
                1, 0, 0, 1, 15'h2, 1, 32'hA500_0002};
    vecs[3] = '{"contest", 1, 32'hC, 1, 0, 32'h43, 0,
                0, 1, 0, 1, 15'h10, 2, 32'hDEAD_BEEF};
    vecs[4] = '{"fetch0c", 1, 32'hC, 0, 0, 0, 0,
                1, 0, 0, 1, 15'h3, 1, 32'hA500_0003};
    vecs[5] = '{"idle", 0, 0, 0, 0, 0, 0,
                0, 0, 0, 0, 15'h0, 0, 32'h0};
    vecs[6] = '{"storeEcho", 1, 32'h0, 1, 1, 32'h104, 32'h1234_5678,
                0, 1, 1, 1, 15'h41, 2, 32'h1234_5678};
    vecs[7] = '{"fetch104", 1, 32'h104, 0, 0, 0, 0,
                1, 0, 0, 1, 15'h41, 1, 32'h1234_5678};
    vecs[8] = '{"addrWrap", 1, 32'h0002_0010, 0, 0, 0, 0,
                1, 0, 0, 1, 15'h4, 1, 32'hA500_0004};

    // Reset hold-off with both requesters valid
    reset_n = 1'b0;
    setIn(1, 32'h8, 1, 0, 32'h40, 0, 1, 1);
    @(negedge clk);
    check("rst_ifRdy", {31'b0, if_req_ready}, 0);
    check("rst_dRdy", {31'b0, d_req_ready}, 0);
    check("rst_we", {31'b0, mem_we}, 0);
    check("rst_ifRspV", {31'b0, if_rsp_valid}, 0);
    check("rst_dRspV", {31'b0, d_rsp_valid}, 0);
    check("rst_ifData", if_rsp_data, 0);
    check("rst_dData", d_rsp_data, 0);
    nextCycle();
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_dRdy", {31'b0, d_req_ready}, 1);
    check("rel_ifRdy", {31'b0, if_req_ready}, 0);
    nextCycle();
    check("rel_dRspV", {31'b0, d_rsp_valid}, 1);
    check("rel_dData", d_rsp_data, 32'hA500_0010);

    // Table vectors, responses always consumed
    for (int v = 0; v < 9; v++) begin
      setIn(vecs[v].ifv, vecs[v].ifa, vecs[v].dv, vecs[v].we,
            vecs[v].da, vecs[v].wd, 1, 1);
      @(negedge clk);
      check({vecs[v].name, "_ifRdy"}, {31'b0, if_req_ready},
            {31'b0, vecs[v].expIfRdy});
      check({vecs[v].name, "_dRdy"}, {31'b0, d_req_ready},
            {31'b0, vecs[v].expDRdy});
      check({vecs[v].name, "_we"}, {31'b0, mem_we},
            {31'b0, vecs[v].expWe});
      if (vecs[v].chkAddr)
        check({vecs[v].name, "_addr"}, {17'b0, mem_addr},
              {17'b0, vecs[v].expAddr});
      nextCycle();
      check({vecs[v].name, "_ifRspV"}, {31'b0, if_rsp_valid},
            (vecs[v].expRsp == 1) ? 32'd1 : 32'd0);
      check({vecs[v].name, "_dRspV"}, {31'b0, d_rsp_valid},
            (vecs[v].expRsp == 2) ? 32'd1 : 32'd0);
      if (vecs[v].expRsp == 1)
        check({vecs[v].name, "_ifData"}, if_rsp_data, vecs[v].expData);
      if (vecs[v].expRsp == 2)
        check({vecs[v].name, "_dData"}, d_rsp_data, vecs[v].expData);
    end

    // Back-pressure on the data response blocks a pending fetch
    setIn(0, 0, 1, 0, 32'h40, 0, 1, 0);
    @(negedge clk);
    check("bp_grant", {31'b0, d_req_ready}, 1);
    nextCycle();
    setIn(1, 32'h10, 0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_ifRdy", {31'b0, if_req_ready}, 0);
      check("bp_we", {31'b0, mem_we}, 0);
      check("bp_dRspV", {31'b0, d_rsp_valid}, 1);
      check("bp_dData", d_rsp_data, 32'hDEAD_BEEF);
      nextCycle();
    end
    d_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_relIfRdy", {31'b0, if_req_ready}, 1);
    check("bp_relAddr", {17'b0, mem_addr}, 32'h4);
    nextCycle();
    check("bp_ifRspV", {31'b0, if_rsp_valid}, 1);
    check("bp_dRspV0", {31'b0, d_rsp_valid}, 0);
    check("bp_ifData", if_rsp_data, 32'hA500_0004);

    // Streaming fetches, one per cycle
    for (int i = 0; i < 8; i++) begin
      setIn(1, 32'(i * 4), 0, 0, 0, 0, 1, 1);
      @(negedge clk);
      check("st_ifRdy", {31'b0, if_req_ready}, 1);
      check("st_addr", {17'b0, mem_addr}, 32'(i));
      nextCycle();
      check("st_ifRspV", {31'b0, if_rsp_valid}, 1);
      check("st_ifData", if_rsp_data, 32'hA500_0000 | 32'(i));
    end

    // Reset while a fetch response is held; a store offered is dropped
    setIn(0, 0, 1, 1, 32'h80, 32'h55, 0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_ifRspV", {31'b0, if_rsp_valid}, 0);
    check("mid_ifData", if_rsp_data, 0);
    check("mid_dRdy", {31'b0, d_req_ready}, 0);
    check("mid_we", {31'b0, mem_we}, 0);
    nextCycle();
    reset_n = 1'b1;
    setIn(0, 0, 1, 0, 32'h80, 0, 1, 1);
    @(negedge clk);
    check("mid_loadRdy", {31'b0, d_req_ready}, 1);
    nextCycle();
    check("mid_loadData", d_rsp_data, 32'hA500_0020);

    // Both requesters held: fairness pattern
    setIn(1, 32'h4, 1, 0, 32'h0, 0, 1, 1);
    for (int g = 0; g < 10; g++) begin
      logic expD;
`ifdef MEM_ARB_FAIRNESS_EN
      expD = (g % 5) != 4;
`else
      expD = 1'b1;
`endif
      @(negedge clk);
      check("fair_dRdy", {31'b0, d_req_ready}, {31'b0, expD});
      check("fair_ifRdy", {31'b0, if_req_ready}, {31'b0, !expD});
      nextCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
